ntt_addr_gen: RTL and testbench

NTT_ADDR_GEN -- requirements
Module: ntt_addr_gen

---
 rtl/ntt_addr_gen.sv | 177 +++++++++++++++++
 tb/tb_ntt_addr_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen -- address/control sequencer for a 256-point in-place NTT/INTT.
//
// Seven layers of 128 butterfly pairs are issued. Each issued pair is
// written back D = RD_LAT + BF_LAT cycles later. Before the next layer
// starts, the sequencer waits until the last write of the current layer
// has retired.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, mode           start pulse (sampled in IDLE), 0 = NTT / 1 = INTT
//   hold                  stall issue for this cycle (honoured only in ISSUE)
//   busy, done            transform in progress / one-cycle completion pulse
//   rd_valid, rd_addr_a/b pair read issue and coefficient addresses
//   twf_idx               twiddle ROM index for the issued pair
//   sel                   captured mode, aligned with read data
//   wr_valid, wr_addr_a/b butterfly write-back strobe and addresses
//   layer                 current layer 0..6
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing pairs i = 0..127 of the current layer
// DRAIN | waiting D cycles for the layer's last write-back
// FIN   | done pulse, returning to IDLE
module ntt_addr_gen #(
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       hold,
  output logic       busy,
  output logic       rd_valid,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [6:0] twf_idx,
  output logic       sel,
  output logic       wr_valid,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b,
  output logic [2:0] layer,
  output logic       done
);

  localparam int D = RD_LAT + BF_LAT;
  localparam logic [3:0] DRAIN_INIT = 4'(D - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t      state;
  logic        mode_q;
  logic [6:0]  idx;
  logic [3:0]  drain_cnt;

  logic [2:0]  lg;
  logic [3:0]  sh;
  logic [6:0]  grp;
  logic [6:0]  jmask;
  logic [6:0]  jj;
  logic [7:0]  len_c;
  logic [7:0]  addr_a_c;
  logic [7:0]  addr_b_c;
  logic [6:0]  twf_c;

  logic             dl_v [D];
  logic [7:0]       dl_a [D];
  logic [7:0]       dl_b [D];
  logic [RD_LAT-1:0] sel_pipe;

  // lg = log2(len). The group base is g * 2 * len, which is g << (lg + 1).
  // The INTT twiddle index (128 >> layer) - 1 - g is written as
  // (127 >> layer) - g so that it fits in 7 bits.
  always_comb begin
    lg       = mode_q ? (layer + 3'd1) : (3'd7 - layer);
    sh       = {1'b0, lg} + 4'd1;
    grp      = idx >> lg;
    jmask    = 7'h7f >> (3'd7 - lg);
    jj       = idx & jmask;
    len_c    = 8'd1 << lg;
    addr_a_c = ({1'b0, grp} << sh) | {1'b0, jj};
    addr_b_c = addr_a_c + len_c;
    twf_c    = mode_q ? ((7'h7f >> layer) - grp) : ((7'd1 << layer) + grp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      idx       <= '0;
      drain_cnt <= '0;
      layer     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      twf_idx   <= '0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= ISSUE;
            mode_q <= mode;
            busy   <= 1'b1;
            layer  <= '0;
            idx    <= '0;
          end
        end
        ISSUE: begin
          if (!hold) begin
            rd_valid  <= 1'b1;
            rd_addr_a <= addr_a_c;
            rd_addr_b <= addr_b_c;
            twf_idx   <= twf_c;
            idx       <= idx + 7'd1;
            if (idx == 7'd127) begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_INIT;
            end
          end
        end
        DRAIN: begin
          // The last write-back lands on the edge where the count reaches
          // zero, so the next layer's first read cannot overtake it.
          if (drain_cnt == 4'd0) begin
            if (layer == 3'd6) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= ISSUE;
              layer <= layer + 3'd1;
            end
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back delay line. It advances every cycle, independent of hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < D; k++) begin
        dl_v[k] <= 1'b0;
        dl_a[k] <= '0;
        dl_b[k] <= '0;
      end
      sel_pipe <= '0;
    end else begin
      dl_v[0] <= rd_valid;
      dl_a[0] <= rd_addr_a;
      dl_b[0] <= rd_addr_b;
      for (int k = 1; k < D; k++) begin
        dl_v[k] <= dl_v[k-1];
        dl_a[k] <= dl_a[k-1];
        dl_b[k] <= dl_b[k-1];
      end
      sel_pipe[0] <= mode_q;
      for (int k = 1; k < RD_LAT; k++) sel_pipe[k] <= sel_pipe[k-1];
    end
  end

  assign wr_valid  = dl_v[D-1];
  assign wr_addr_a = dl_a[D-1];
  assign wr_addr_b = dl_b[D-1];
  assign sel       = sel_pipe[RD_LAT-1];

endmodule

// File: tb/tb_ntt_addr_gen.sv
module tb_ntt_addr_gen;
  localparam int RD_LAT = 1;
  localparam int BF_LAT = 5;
  localparam int D = RD_LAT + BF_LAT;

  logic clk = 1'b0;
  logic rst, start, mode, hold;
  logic busy, rd_valid, sel, wr_valid, done;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [6:0] twf_idx;
  logic [2:0] layer;

  int errors = 0;
  int checks = 0;

  typedef struct {int a; int b; int t; int l;} rd_t;
  typedef struct {int a; int b; int due;} wr_t;

  ntt_addr_gen #(.RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .hold(hold),
    .busy(busy), .rd_valid(rd_valid), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .twf_idx(twf_idx), .sel(sel), .wr_valid(wr_valid), .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b), .layer(layer), .done(done)
  );

  always #5 clk = ~clk;

  // Reference pair from the index arithmetic. In INTT mode the last layer
  // (one group of length 128) yields twiddle index 1, the mirror of the
  // NTT's first layer.
  function automatic rd_t ref_pair(input bit m, input int l, input int i);
    rd_t r;
    int len, g, j;
    len = m ? (2 << l) : (128 >> l);
    g = i / len;
    j = i % len;
    r.a = g * 2 * len + j;
    r.b = r.a + len;
    r.t = m ? ((128 >> l) - 1 - g) : ((1 << l) + g);
    r.l = l;
    return r;
  endfunction

  task automatic test_reset();
    rst = 1; start = 1; mode = 1; hold = 0;
    repeat (3) @(negedge clk);
    rst = 0; start = 0;
    checks++;
    if ({busy, rd_valid, wr_valid, done, sel} !== 5'b0)
      begin errors++; $display("FAIL reset_ctrl: busy=%b rd_valid=%b wr_valid=%b done=%b sel=%b want all 0", busy, rd_valid, wr_valid, done, sel); end
    checks++;
    if ({rd_addr_a, rd_addr_b, twf_idx} !== 23'b0)
      begin errors++; $display("FAIL reset_rd_addr: a=%0d b=%0d twf=%0d want 0", rd_addr_a, rd_addr_b, twf_idx); end
    checks++;
    if ({wr_addr_a, wr_addr_b, layer} !== 19'b0)
      begin errors++; $display("FAIL reset_wr_addr: a=%0d b=%0d layer=%0d want 0", wr_addr_a, wr_addr_b, layer); end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_valid !== 1'b0)
      begin errors++; $display("FAIL reset_dominates_start: busy=%b rd_valid=%b want 0", busy, rd_valid); end
  endtask

  // Runs one transform, checking every issue and write-back against the model.
  // rst_after > 0 aborts with a reset once that many reads have been seen.
  task automatic run_xform(input bit m, input int hold_pct, input bit stray_start,
                           input bit hold_at5, input int rst_after, input string tag);
    rd_t exp_rd[$];
    wr_t exp_wr[$];
    rd_t e;
    wr_t w;
    int rd_cnt, wr_cnt, done_cnt, cyc, last_rd_cyc, hold_left;
    bit hold_prev, check_resume, resume_arm, finished;
    for (int l = 0; l < 7; l++)
      for (int i = 0; i < 128; i++) exp_rd.push_back(ref_pair(m, l, i));
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; cyc = 0; last_rd_cyc = 0; hold_left = 0;
    hold_prev = 0; check_resume = 0; resume_arm = 0; finished = 0;

    @(negedge clk); start = 1; mode = m; hold = 0;
    @(negedge clk); start = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start: got %b want 1", tag, busy); end

    while (!finished && cyc < 4000) begin
      if (hold_prev) begin
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL %s hold_issue: rd_valid=%b want 0", tag, rd_valid); end
      end
      if (check_resume) begin
        checks++;
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL %s hold_resume: rd_valid=%b want 1", tag, rd_valid); end
        check_resume = 0;
      end
      if (rd_valid === 1'b1) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++; $display("FAIL %s extra_read: a=%0d b=%0d want none", tag, rd_addr_a, rd_addr_b);
        end else begin
          e = exp_rd.pop_front();
          if (int'(rd_addr_a) != e.a || int'(rd_addr_b) != e.b || int'(twf_idx) != e.t || int'(layer) != e.l) begin
            errors++;
            $display("FAIL %s rd_pair #%0d: got a=%0d b=%0d twf=%0d layer=%0d want a=%0d b=%0d twf=%0d layer=%0d",
                     tag, rd_cnt, rd_addr_a, rd_addr_b, twf_idx, layer, e.a, e.b, e.t, e.l);
          end
          if (rd_cnt > 0 && rd_cnt % 128 == 0) begin
            checks++;
            if (wr_cnt != rd_cnt || cyc - last_rd_cyc < 6) begin
              errors++;
              $display("FAIL %s layer_gap: writes=%0d gap=%0d want writes=%0d gap>=6", tag, wr_cnt, cyc - last_rd_cyc, rd_cnt);
            end
          end
          exp_wr.push_back('{e.a, e.b, cyc + D});
        end
        rd_cnt++;
        last_rd_cyc = cyc;
        if (hold_at5 && rd_cnt == 5) hold_left = 3;
      end
      if (exp_wr.size() > 0 && exp_wr[0].due < cyc) begin
        errors++; checks++;
        $display("FAIL %s wr_missing: due cycle %0d passed at %0d", tag, exp_wr[0].due, cyc);
        void'(exp_wr.pop_front());
      end
      if (wr_valid === 1'b1) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++; $display("FAIL %s extra_write: a=%0d b=%0d want none", tag, wr_addr_a, wr_addr_b);
        end else begin
          w = exp_wr.pop_front();
          if (int'(wr_addr_a) != w.a || int'(wr_addr_b) != w.b || cyc != w.due || sel !== m) begin
            errors++;
            $display("FAIL %s wr_pair: got a=%0d b=%0d cyc=%0d sel=%b want a=%0d b=%0d cyc=%0d sel=%b",
                     tag, wr_addr_a, wr_addr_b, cyc, sel, w.a, w.b, w.due, m);
          end
        end
        wr_cnt++;
      end
      if (done === 1'b1) begin
        checks++;
        done_cnt++;
        if (rd_cnt != 896 || wr_cnt != 896 || done_cnt != 1) begin
          errors++;
          $display("FAIL %s done_totals: reads=%0d writes=%0d dones=%0d want 896/896/1", tag, rd_cnt, wr_cnt, done_cnt);
        end
        finished = 1;
      end
      if (rst_after > 0 && rd_cnt == rst_after) begin
        rst = 1; hold = 0; start = 0;
        @(negedge clk); rst = 0;
        checks++;
        if ({busy, rd_valid, wr_valid, done, sel, rd_addr_a, rd_addr_b, twf_idx, wr_addr_a, wr_addr_b, layer} !== '0) begin
          errors++;
          $display("FAIL %s abort_outputs: busy=%b rd=%b wr=%b done=%b sel=%b ra=%0d rb=%0d twf=%0d wa=%0d wb=%0d layer=%0d want all 0",
                   tag, busy, rd_valid, wr_valid, done, sel, rd_addr_a, rd_addr_b, twf_idx, wr_addr_a, wr_addr_b, layer);
        end
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          checks++;
          if (wr_valid !== 1'b0 || rd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s abort_quiet: wr=%b rd=%b busy=%b want 0", tag, wr_valid, rd_valid, busy);
          end
        end
        return;
      end
      if (!finished) begin
        if (hold_left > 0) begin
          hold = 1; hold_left--;
          if (hold_left == 0) resume_arm = 1;
        end else if (resume_arm) begin
          hold = 0; check_resume = 1; resume_arm = 0;
        end else begin
          hold = ($urandom_range(99) < hold_pct);
        end
        mode  = 1'($urandom);
        start = stray_start && ($urandom_range(49) == 0);
      end else begin
        hold = 0; start = 0;
      end
      hold_prev = hold;
      @(negedge clk);
      cyc++;
    end
    hold = 0; start = 0;
    checks++;
    if (!finished) begin errors++; $display("FAIL %s timeout: reads=%0d writes=%0d want done", tag, rd_cnt, wr_cnt); end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s after_done: done=%b busy=%b want 0", tag, done, busy); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0 || wr_valid !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL %s idle_quiet: rd=%b wr=%b done=%b want 0", tag, rd_valid, wr_valid, done);
      end
    end
  endtask

  task automatic test_ntt();                run_xform(1'b0, 0, 1'b0, 1'b0, 0, "ntt"); endtask
  task automatic test_intt();               run_xform(1'b1, 0, 1'b0, 1'b0, 0, "intt"); endtask
  task automatic test_hold();               run_xform(1'b0, 0, 1'b0, 1'b1, 0, "hold3"); endtask
  task automatic test_random_hold();
    run_xform(1'b0, 30, 1'b0, 1'b0, 0, "rand_hold_ntt");
    run_xform(1'b1, 30, 1'b0, 1'b0, 0, "rand_hold_intt");
  endtask
  task automatic test_start_while_busy();   run_xform(1'($urandom), 10, 1'b1, 1'b0, 0, "start_busy"); endtask
  task automatic test_reset_mid();
    run_xform(1'b0, 0, 1'b0, 1'b0, 3 * 128 + 41, "reset_mid");
    run_xform(1'b0, 0, 1'b0, 1'b0, 0, "after_reset");
  endtask
  task automatic test_back_to_back();
    run_xform(1'b1, 5, 1'b0, 1'b0, 0, "b2b_a");
    run_xform(1'b0, 5, 1'b0, 1'b0, 0, "b2b_b");
  endtask

  initial begin
    rst = 1; start = 0; mode = 0; hold = 0;
    test_reset();
    test_ntt();
    test_intt();
    test_hold();
    test_random_hold();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
